// File: rtl/bram_access_arbiter.sv
// bram_access_arbiter: PS->PL BRAM ownership handoff and round-robin sharing of one PL BRAM port.
// Optional macro ARB_STARVE_LIMIT_EN adds per-requester wait counters and the starve_flag output.
module bram_access_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = 10,
   parameter int DATA_W  = 16
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      ps_done,
   output logic                      pl_sel,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ-1:0]        req_we,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
   output logic [NUM_REQ-1:0]        grant,
   output logic [NUM_REQ-1:0]        rvalid,
   output logic [DATA_W-1:0]         rdata,
   output logic                      bram_en,
   output logic                      bram_we,
   output logic [ADDR_W-1:0]         bram_addr,
   output logic [DATA_W-1:0]         bram_wdata,
   input  logic [DATA_W-1:0]         bram_rdata
`ifdef ARB_STARVE_LIMIT_EN
   ,
   output logic [NUM_REQ-1:0]        starve_flag
`endif
);
   localparam int PW = $clog2(NUM_REQ);
   localparam logic [PW:0] NR = (PW+1)'(NUM_REQ);
   localparam logic [1:0] PS_OWN = 2'd0, HANDOFF = 2'd1, PL_OWN = 2'd2, DRAIN = 2'd3;
   logic [1:0]         state;
   logic [PW-1:0]      ptr, win, cmd_id, s1_id;
   logic [PW:0]        j;
   logic [NUM_REQ-1:0] elig;
   logic               found, s1;
   assign pl_sel = state != PS_OWN;
   // Scan downward so the last hit is the first eligible index at or after ptr
   always_comb begin
      elig = (state == PL_OWN) ? req & ~grant : '0;
      found = |elig;
      win = '0;
      j = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         j = {1'b0, ptr} + (PW+1)'(k);
         j = (j >= NR) ? j - NR : j;
         if (elig[j[PW-1:0]]) win = j[PW-1:0];
      end
`ifdef ARB_STARVE_LIMIT_EN
      for (int k = NUM_REQ - 1; k >= 0; k--)
         if (elig[k] && starve_flag[k]) win = PW'(k);
`endif
   end
   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         state      <= PS_OWN;
         ptr        <= '0;
         grant      <= '0;
         bram_en    <= 1'b0;
         bram_we    <= 1'b0;
         bram_addr  <= '0;
         bram_wdata <= '0;
         cmd_id     <= '0;
         s1         <= 1'b0;
         s1_id      <= '0;
         rvalid     <= '0;
         rdata      <= '0;
      end else begin
         state <= (state == PS_OWN)  ? (ps_done ? HANDOFF : PS_OWN) :
                  (state == HANDOFF) ? PL_OWN :
                  (state == PL_OWN)  ? (ps_done ? PL_OWN : DRAIN) :
                  (!bram_en && !s1)  ? PS_OWN : DRAIN;
         grant   <= found ? NUM_REQ'(1) << win : '0;
         bram_en <= found;
         bram_we <= found && req_we[win];
         if (found) begin
            bram_addr  <= req_addr[win*ADDR_W +: ADDR_W];
            bram_wdata <= req_wdata[win*DATA_W +: DATA_W];
            cmd_id     <= win;
            ptr        <= (win == PW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
         end
         // Read id travels with the BRAM latency so the data returns to its issuer
         s1     <= bram_en && !bram_we;
         s1_id  <= cmd_id;
         rvalid <= s1 ? NUM_REQ'(1) << s1_id : '0;
         if (s1) rdata <= bram_rdata;
      end
`ifdef ARB_STARVE_LIMIT_EN
   for (genvar i = 0; i < NUM_REQ; i++) begin : g_wait
      logic [3:0] wait_cnt;
      assign starve_flag[i] = wait_cnt == 4'd15;
      always_ff @(posedge clock or posedge reset)
         if (reset) wait_cnt <= '0;
         else if (grant[i]) wait_cnt <= '0;
         else if (req[i] && !starve_flag[i]) wait_cnt <= wait_cnt + 4'd1;
   end
`endif
endmodule

// File: tb/tb_bram_access_arbiter.sv
// tb_bram_access_arbiter: randomized bench with a transaction-level reference model of the arbiter.
module tb_bram_access_arbiter;
   localparam int N = 4, AW = 10, DW = 16;
   localparam int ALL = 0, ONLY2 = 1, RND = 2;
   logic clock = 1'b0, reset = 1'b1, ps_done = 1'b0;
   logic [N-1:0] req = '0, req_we = '0;
   logic [N*AW-1:0] req_addr = '0;
   logic [N*DW-1:0] req_wdata = '0;
   logic [N-1:0] grant, rvalid;
   logic [DW-1:0] rdata, bram_wdata, bram_rdata;
   logic bram_en, bram_we, pl_sel;
   logic [AW-1:0] bram_addr;
`ifdef ARB_STARVE_LIMIT_EN
   logic [N-1:0] starve_flag;
`endif
   logic [DW-1:0] mem [1<<AW];
   logic [DW-1:0] ref_mem [1<<AW];
   int n_chk = 0, n_err = 0, mode = ALL, cyc = 0;
   int ms, mptr, last_cmd, last_rd;
   int wc [N];
   logic [N-1:0] mgrant, e_rvalid;
   logic e_en, e_we;
   logic [AW-1:0] e_addr;
   logic [DW-1:0] e_wdata, e_rdata;
   bit ev_v [4];
   int ev_id [4];
   logic [DW-1:0] ev_d [4];

   always #5 clock = ~clock;

   bram_access_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
      .clock(clock), .reset(reset), .ps_done(ps_done), .pl_sel(pl_sel),
      .req(req), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
      .grant(grant), .rvalid(rvalid), .rdata(rdata),
      .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
      .bram_wdata(bram_wdata), .bram_rdata(bram_rdata)
`ifdef ARB_STARVE_LIMIT_EN
      , .starve_flag(starve_flag)
`endif
   );

   function automatic logic [DW-1:0] init_word(int a);
      return (a == 'h155) ? 16'hBEEF : DW'(a * 37) ^ 16'hA5A5;
   endfunction

   // BRAM: read-first, one cycle read latency
   initial begin
      bram_rdata = '0;
      for (int a = 0; a < (1 << AW); a++) mem[a] = init_word(a);
      forever begin
         @(posedge clock);
         if (bram_en) begin
            bram_rdata <= mem[bram_addr];
            if (bram_we) mem[bram_addr] <= bram_wdata;
         end
      end
   end

   task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, got, exp);
      end
   endtask

   task automatic model_reset();
      ms = 0; mptr = 0; last_cmd = -100; last_rd = -100;
      mgrant = '0; e_rvalid = '0; e_en = 0; e_we = 0; e_addr = '0; e_wdata = '0; e_rdata = '0;
      for (int i = 0; i < 4; i++) ev_v[i] = 0;
      for (int i = 0; i < N; i++) wc[i] = 0;
   endtask

   task automatic model_step();
      logic [N-1:0] el;
      int w, nxt;
      el = (ms == 2) ? req & ~mgrant : '0;
      w = -1;
      for (int k = 0; k < N; k++)
         if (w < 0 && el[(mptr + k) % N]) w = (mptr + k) % N;
`ifdef ARB_STARVE_LIMIT_EN
      for (int k = 0; k < N; k++)
         if (el[k] && wc[k] == 15) begin w = k; break; end
      for (int i = 0; i < N; i++)
         wc[i] = mgrant[i] ? 0 : (req[i] && wc[i] < 15) ? wc[i] + 1 : wc[i];
`endif
      e_rvalid = '0;
      if (ev_v[cyc % 4]) begin
         e_rvalid = N'(1) << ev_id[cyc % 4];
         e_rdata = ev_d[cyc % 4];
         ev_v[cyc % 4] = 0;
      end
      case (ms)
         0: nxt = ps_done ? 1 : 0;
         1: nxt = 2;
         2: nxt = ps_done ? 2 : 3;
         default: nxt = (cyc > last_cmd + 1 && cyc > last_rd + 2) ? 0 : 3;
      endcase
      if (w >= 0) begin
         mgrant = N'(1) << w;
         e_en = 1;
         e_we = req_we[w];
         e_addr = req_addr[w*AW +: AW];
         e_wdata = req_wdata[w*DW +: DW];
         mptr = (w + 1) % N;
         last_cmd = cyc;
         if (e_we) ref_mem[e_addr] = e_wdata;
         else begin
            last_rd = cyc;
            ev_v[(cyc + 2) % 4] = 1;
            ev_id[(cyc + 2) % 4] = w;
            ev_d[(cyc + 2) % 4] = ref_mem[e_addr];
         end
      end else begin
         mgrant = '0; e_en = 0; e_we = 0;
      end
      ms = nxt;
   endtask

   task automatic compare_all();
      check("grant", grant, mgrant);
      check("rvalid", rvalid, e_rvalid);
      check("rdata", rdata, e_rdata);
      check("pl_sel", pl_sel, ms != 0);
      check("bram_en", bram_en, e_en);
      check("bram_we", bram_we, e_we);
      check("bram_addr", bram_addr, e_addr);
      check("bram_wdata", bram_wdata, e_wdata);
`ifdef ARB_STARVE_LIMIT_EN
      for (int i = 0; i < N; i++) check("starve_flag", starve_flag[i], wc[i] == 15);
`endif
   endtask

   task automatic drive();
      for (int i = 0; i < N; i++) begin
         if (req[i] && !mgrant[i]) continue;
         req[i] = (mode == ALL) ? 1'b1 : (mode == ONLY2) ? (i == 2) : ($urandom_range(0, 2) != 0);
         req_we[i] = (mode == ONLY2) ? 1'b0 : 1'($urandom_range(0, 1));
         req_addr[i*AW +: AW] = (mode == ONLY2) ? AW'('h155) : AW'($urandom_range(0, 63));
         req_wdata[i*DW +: DW] = DW'($urandom);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
      cyc++;
      model_step();
      compare_all();
      drive();
   endtask

   task automatic run(int n);
      for (int c = 0; c < n; c++) step();
   endtask

   initial begin
      for (int a = 0; a < (1 << AW); a++) ref_mem[a] = init_word(a);
      model_reset();
      repeat (2) @(posedge clock);
      #1;
      compare_all();
      reset = 1'b0;
      mode = ALL;
      drive();
      run(10);
      ps_done = 1'b1;
      run(20);
      mode = RND;
      run(60);
      mode = ONLY2;
      run(12);
      mode = RND;
      ps_done = 1'b0;
      run(12);
      ps_done = 1'b1;
      run(30);
      for (int c = 0; c < 300; c++) begin
         if ($urandom_range(0, 15) == 0) ps_done = ~ps_done;
         step();
      end
      // Asynchronous reset while a read is in flight
      ps_done = 1'b1;
      for (int c = 0; c < 40 && !(ev_v[0] || ev_v[1] || ev_v[2] || ev_v[3]); c++) step();
      #2 reset = 1'b1;
      #1 model_reset();
      compare_all();
      @(posedge clock);
      #1;
      compare_all();
      for (int a = 0; a < (1 << AW); a++) ref_mem[a] = mem[a];
      reset = 1'b0;
      // Hold requests while the PS owns the BRAM long enough to saturate wait counters
      ps_done = 1'b0;
      for (int c = 0; c < 60 && pl_sel; c++) step();
      check("drain_done", pl_sel, 1'b0);
      mode = RND;
      run(25);
      ps_done = 1'b1;
      mode = ALL;
      run(30);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/bram_access_arbiter.md
Name: bram_access_arbiter

Overview:
Controller for the shared dual-port weight/spike BRAM. It sequences ownership handoff from the PS (AXI-Lite loader) to the PL, and shares one BRAM port among NUM_REQ PL requesters (SNN neuron-core engines) using round-robin arbitration. It drives the PL-side port signals and the PS/PL select line of the BRAM mux, and routes read data back to the requester that issued the read.

Parameters:
NUM_REQ, 4, number of PL requesters (2..8)
ADDR_W, 10, BRAM address width
DATA_W, 16, BRAM data width

Ports:
clock  in  1  single clock for all logic
reset  in  1  asynchronous, active-high reset
ps_done  in  1  level; high = PS finished loading, PL may own BRAM
pl_sel  out  1  BRAM mux select; 1 = PL drives BRAM
req  in  NUM_REQ  per-requester access request, held until granted
req_we  in  NUM_REQ  per-requester write enable
req_addr  in  NUM_REQ*ADDR_W  flattened addresses; requester i at [i*ADDR_W +: ADDR_W]
req_wdata  in  NUM_REQ*DATA_W  flattened write data
grant  out  NUM_REQ  one-hot grant pulse
rvalid  out  NUM_REQ  one-hot read-data-valid pulse
rdata  out  DATA_W  read data, broadcast to all requesters
bram_en  out  1  BRAM port enable (registered)
bram_we  out  1  BRAM write enable (registered)
bram_addr  out  ADDR_W  BRAM address (registered)
bram_wdata  out  DATA_W  BRAM write data (registered)
bram_rdata  in  DATA_W  BRAM read data, 1-cycle latency after bram_en

Behaviour:
- Reset: state PS_OWN. pl_sel, grant, rvalid, bram_en and bram_we are 0. bram_addr, bram_wdata and rdata are 0. RR pointer is 0. The read pipe is empty.
- FSM:
  - PS_OWN -> HANDOFF when ps_done=1.
  - HANDOFF lasts exactly 1 cycle. pl_sel=1 and no command is issued (mux/clock settle). Then -> PL_OWN.
  - PL_OWN -> DRAIN when ps_done=0.
  - DRAIN issues no grants. It -> PS_OWN once the read pipe is empty and no command is in flight. pl_sel=0 on entry to PS_OWN.
- pl_sel=1 in HANDOFF, PL_OWN and DRAIN.
- Arbitration (PL_OWN only), cycle t:
  - Eligible set = req & ~grant. A requester currently being granted is ineligible in that cycle, which prevents a double grant of a held request.
  - Winner = first eligible index searching upward from the RR pointer, with wrap.
  - At edge t+1:
    - grant[winner]=1 for exactly one cycle.
    - bram_en=1, bram_we=req_we[winner], bram_addr and bram_wdata taken from the winner.
    - RR pointer = winner+1 mod NUM_REQ.
  - No eligible requester: bram_en=0, bram_we=0, addr/wdata hold, pointer holds.
- Requester drops or changes req in the cycle it sees grant. Max rate is one access per requester per 2 cycles; with ≥2 active requesters the port is used every cycle.
- Reads:
  - A read command driven in cycle t+1 returns bram_rdata in t+2.
  - The arbiter registers it: rdata and rvalid[id] are valid in t+3. Total read latency is 2 cycles after grant.
  - The winner id and a read flag are pipelined alongside.
  - Writes produce no rvalid.
- ps_done falls while requests are pending: they stay ungranted and are not lost. They are served after the next PS_OWN->PL_OWN cycle.
- ps_done re-rises during DRAIN: DRAIN completes to PS_OWN first, then a normal HANDOFF.
- An in-flight read at DRAIN entry still delivers its rvalid/rdata.
- Reset asserted mid-operation: everything returns to reset values immediately and asynchronously. Outstanding reads are discarded (no rvalid).

Optional Feature:
ARB_STARVE_LIMIT_EN
- Defined:
  - Per-requester 4-bit wait counter. It increments each cycle the requester has req=1 and is not granted, and clears on grant.
  - When a counter reaches 15, that requester has absolute priority at the next arbitration, overriding the RR order. Among several saturated requesters, the lowest index wins.
  - An extra output, starve_flag (NUM_REQ), is 1 while the corresponding counter is saturated.
- Undefined: pure round-robin. No counters and no starve_flag port.

Test Plan:
- Reset, ps_done=0, req=4'b1111 for 10 cycles -> grant=0, bram_en=0, pl_sel=0 throughout.
- ps_done 0->1 at cycle 5 -> pl_sel=1 at edge 6 (HANDOFF), no command at 6, first grant/bram_en at edge 8 at the earliest.
- PL_OWN, req=4'b1111 held, each requester re-requesting after grant -> grants 0,1,2,3,0,… one per cycle, bram_en=1 every cycle.
- Requester 2 reads addr 0x155 where BRAM holds 0xBEEF, granted at cycle t -> bram_addr=0x155 at t, rvalid=4'b0100 and rdata=0xBEEF at t+2.
- Read granted, then ps_done dropped in the same cycle -> its rvalid still arrives; no further grants; pl_sel=0 one cycle after the pipe is empty; a pending req[1] is granted after ps_done returns.
- Reset pulsed while a read is in flight -> no rvalid, all outputs 0, state PS_OWN; with ARB_STARVE_LIMIT_EN, a requester blocked 15 cycles by forced higher traffic shows starve_flag=1 and wins the next grant.
